// File: rtl/endec_frame_loader.sv
// endec_frame_loader: byte-serial loader assembling encoder/decoder frames, launching the codec and carrying encoder state between frames.
// Ports: sys_clk/rst (async active-low) | i_mode, i_code_rate latched on the first byte
//   | i_byte_data/i_byte_valid/o_byte_ready byte intake | i_flush pad-and-launch | i_stream_clear zero carried state
//   | o_en, o_code_rate, o_encoder_data_frame, o_decoder_data_frame codec side | i_encoder_done/i_decoder_done
//   | o_prv_encoder_state carried state | o_busy, o_error status.
// Build option: define FRAME_LOADER_TIMEOUT_EN to add the RUN watchdog (TIMEOUT_CYCLES); otherwise o_error is 0.
// MAX_STATE_REG_NUM sets the carried state width (6 if not defined elsewhere).
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 6
`endif
module endec_frame_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            i_mode,
  input  logic                            i_code_rate,
  input  logic [7:0]                      i_byte_data,
  input  logic                            i_byte_valid,
  output logic                            o_byte_ready,
  input  logic                            i_flush,
  input  logic                            i_stream_clear,
  output logic                            o_en,
  output logic                            o_code_rate,
  output logic [127:0]                    o_encoder_data_frame,
  output logic [383:0]                    o_decoder_data_frame,
  output logic [`MAX_STATE_REG_NUM-1:0]   o_prv_encoder_state,
  input  logic                            i_encoder_done,
  input  logic                            i_decoder_done,
  output logic                            o_busy,
  output logic                            o_error
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t     state;
  logic       mode;
  logic [5:0] cnt;
  logic [5:0] cnt_nx;
  logic [5:0] target;
  logic       sel_mode;
  logic       done_hit;
  logic       timeout;
  logic       to_hit;
  assign cnt_nx   = cnt + 6'd1;
  assign target   = mode ? (o_code_rate ? 6'd48 : 6'd32) : 6'd16;
  assign sel_mode = (state == IDLE) ? i_mode : mode;
  assign done_hit = mode ? i_decoder_done : i_encoder_done;
`ifdef FRAME_LOADER_TIMEOUT_EN
  logic [31:0] tcnt;
  assign timeout = (state == RUN) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      tcnt    <= '0;
      o_error <= 1'b0;
      to_hit  <= 1'b0;
    end else begin
      tcnt <= (state == RUN) ? tcnt + 32'd1 : '0;
      if (timeout) begin
        o_error <= 1'b1;
        to_hit  <= 1'b1;
      end else if (state == DONE) begin
        to_hit <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign to_hit  = 1'b0;
  assign o_error = 1'b0;
`endif
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      mode                 <= 1'b0;
      cnt                  <= '0;
      o_en                 <= 1'b0;
      o_code_rate          <= 1'b0;
      o_encoder_data_frame <= '0;
      o_decoder_data_frame <= '0;
      o_prv_encoder_state  <= '0;
      o_busy               <= 1'b0;
      o_byte_ready         <= 1'b0;
    end else begin
      o_byte_ready <= (state == IDLE) || (state == FILL);
      case (state)
        IDLE, FILL: begin
          if (i_byte_valid) begin
            if (sel_mode) o_decoder_data_frame[{cnt, 3'b000} +: 8] <= i_byte_data;
            else o_encoder_data_frame[{cnt[3:0], 3'b000} +: 8] <= i_byte_data;
            cnt <= cnt_nx;
          end
          if (state == IDLE) begin
            if (i_byte_valid) begin
              mode        <= i_mode;
              o_code_rate <= i_code_rate;
              state       <= FILL;
              o_busy      <= 1'b1;
            end
          end else if (i_flush || (i_byte_valid && cnt_nx == target)) begin
            // flush in FILL always has at least the first byte held
            state        <= RUN;
            o_en         <= 1'b1;
            o_byte_ready <= 1'b0;
          end
        end
        RUN: begin
          o_byte_ready <= 1'b0;
          if (done_hit || timeout) begin
            state <= DONE;
            o_en  <= 1'b0;
          end
        end
        default: begin
          state                <= IDLE;
          cnt                  <= '0;
          o_busy               <= 1'b0;
          o_byte_ready         <= 1'b1;
          o_encoder_data_frame <= '0;
          o_decoder_data_frame <= '0;
          if (!mode && !to_hit)
            o_prv_encoder_state <= o_encoder_data_frame[127 -: `MAX_STATE_REG_NUM];
        end
      endcase
      // stream clear wins over the DONE carry-over update
      if (i_stream_clear) o_prv_encoder_state <= '0;
    end
  end
endmodule

// File: tb/tb_endec_frame_loader.sv
// tb_endec_frame_loader: table-driven frame vectors plus hand sequences for flush, reset and watchdog corners.
`ifndef MAX_STATE_REG_NUM
`define MAX_STATE_REG_NUM 6
`endif
module tb_endec_frame_loader;
  logic         sys_clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_mode = 1'b0, i_code_rate = 1'b0, i_byte_valid = 1'b0;
  logic [7:0]   i_byte_data = '0;
  logic         i_flush = 1'b0, i_stream_clear = 1'b0;
  logic         i_encoder_done = 1'b0, i_decoder_done = 1'b0;
  logic         o_byte_ready, o_en, o_code_rate, o_busy, o_error;
  logic [127:0] o_encoder_data_frame;
  logic [383:0] o_decoder_data_frame;
  logic [`MAX_STATE_REG_NUM-1:0] o_prv_encoder_state;
  int checks = 0;
  int failures = 0;
  endec_frame_loader #(.TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .i_mode(i_mode), .i_code_rate(i_code_rate),
    .i_byte_data(i_byte_data), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .i_flush(i_flush), .i_stream_clear(i_stream_clear), .o_en(o_en), .o_code_rate(o_code_rate),
    .o_encoder_data_frame(o_encoder_data_frame), .o_decoder_data_frame(o_decoder_data_frame),
    .o_prv_encoder_state(o_prv_encoder_state), .i_encoder_done(i_encoder_done),
    .i_decoder_done(i_decoder_done), .o_busy(o_busy), .o_error(o_error)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic         mode;
    logic         rate;
    int           n;
    logic         flush;
    logic         clr;
    logic [7:0]   start;
    logic [7:0]   step;
    logic [127:0] enc;
    logic [383:0] dec;
    logic [5:0]   prv;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic load(input logic m, input logic r, input int n, input logic [7:0] s, input logic [7:0] st, input logic f);
    for (int k = 0; k < n; k++) begin
      i_mode       = (k == 0) ? m : ~m;
      i_code_rate  = (k == 0) ? r : ~r;
      i_byte_data  = s + 8'(k) * st;
      i_byte_valid = 1'b1;
      i_flush      = f && (k == n - 1);
      @(posedge sys_clk); #1;
    end
    i_byte_valid = 1'b0;
    i_flush      = 1'b0;
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    chk($sformatf("v%0d_ready_idle", idx), o_byte_ready, 1);
    load(v.mode, v.rate, v.n - 1, v.start, v.step, 1'b0);
    chk($sformatf("v%0d_en_before_last", idx), o_en, 0);
    i_mode       = ~v.mode;
    i_byte_data  = v.start + 8'(v.n - 1) * v.step;
    i_byte_valid = 1'b1;
    i_flush      = v.flush;
    @(posedge sys_clk); #1;
    i_byte_valid = 1'b0;
    i_flush      = 1'b0;
    chk($sformatf("v%0d_en_rise", idx), o_en, 1);
    chk($sformatf("v%0d_ready_run", idx), o_byte_ready, 0);
    chk($sformatf("v%0d_busy_run", idx), o_busy, 1);
    chk($sformatf("v%0d_rate", idx), o_code_rate, v.rate);
    chk($sformatf("v%0d_enc", idx), o_encoder_data_frame, v.enc);
    chk($sformatf("v%0d_dec", idx), o_decoder_data_frame, v.dec);
    if (v.mode) i_encoder_done = 1'b1; else i_decoder_done = 1'b1;
    @(posedge sys_clk); #1;
    i_encoder_done = 1'b0;
    i_decoder_done = 1'b0;
    chk($sformatf("v%0d_en_wrong_done", idx), o_en, 1);
    chk($sformatf("v%0d_enc_hold", idx), o_encoder_data_frame, v.enc);
    chk($sformatf("v%0d_dec_hold", idx), o_decoder_data_frame, v.dec);
    if (v.mode) i_decoder_done = 1'b1; else i_encoder_done = 1'b1;
    @(posedge sys_clk); #1;
    i_encoder_done = 1'b0;
    i_decoder_done = 1'b0;
    chk($sformatf("v%0d_en_drop", idx), o_en, 0);
    chk($sformatf("v%0d_busy_done", idx), o_busy, 1);
    i_stream_clear = v.clr;
    @(posedge sys_clk); #1;
    i_stream_clear = 1'b0;
    chk($sformatf("v%0d_prv", idx), o_prv_encoder_state, v.prv);
    chk($sformatf("v%0d_enc_clr", idx), o_encoder_data_frame, 0);
    chk($sformatf("v%0d_dec_clr", idx), o_decoder_data_frame, 0);
    chk($sformatf("v%0d_busy_idle", idx), o_busy, 0);
    chk($sformatf("v%0d_ready_after", idx), o_byte_ready, 1);
    chk($sformatf("v%0d_error", idx), o_error, 0);
  endtask
  initial begin
    int n;
    tbl[0] = '{1'b0, 1'b0, 16, 1'b0, 1'b0, 8'h00, 8'h01,
               128'h0F0E0D0C0B0A09080706050403020100, 384'h0, 6'h03};
    tbl[1] = '{1'b1, 1'b0, 32, 1'b0, 1'b0, 8'hFF, 8'h00,
               128'h0, {128'h0, {256{1'b1}}}, 6'h03};
    tbl[2] = '{1'b1, 1'b1, 6, 1'b1, 1'b0, 8'h11, 8'h11,
               128'h0, 384'h665544332211, 6'h03};
    tbl[3] = '{1'b0, 1'b0, 16, 1'b0, 1'b1, 8'h80, 8'h01,
               128'h8F8E8D8C8B8A89888786858483828180, 384'h0, 6'h00};
    tbl[4] = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 8'hA0, 8'h01,
               128'hA2A1A0, 384'h0, 6'h00};
    tbl[5] = '{1'b0, 1'b0, 16, 1'b0, 1'b0, 8'hF0, 8'h01,
               128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 384'h0, 6'h3F};
    tbl[6] = '{1'b1, 1'b1, 48, 1'b0, 1'b0, 8'h00, 8'h01, 128'h0,
               384'h2F2E2D2C2B2A292827262524232221201F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100,
               6'h3F};
    #12;
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_en, 0);
    chk("rst_prv", o_prv_encoder_state, 0);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("rel_ready", o_byte_ready, 1);
    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);
    i_flush = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    i_flush = 1'b0;
    chk("idle_flush_busy", o_busy, 0);
    chk("idle_flush_en", o_en, 0);
`ifdef FRAME_LOADER_TIMEOUT_EN
    load(1'b0, 1'b0, 16, 8'h40, 8'h01, 1'b0);
    n = 0;
    while (o_en && n < 20) begin
      n++;
      @(posedge sys_clk); #1;
    end
    chk("to_en_cycles", n, 8);
    chk("to_error", o_error, 1);
    chk("to_busy_done", o_busy, 1);
    @(posedge sys_clk); #1;
    chk("to_prv_kept", o_prv_encoder_state, 6'h3F);
    chk("to_error_sticky", o_error, 1);
    chk("to_idle", o_busy, 0);
`else
    load(1'b0, 1'b0, 16, 8'h40, 8'h01, 1'b0);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_en) n++;
      @(posedge sys_clk); #1;
    end
    chk("wait_en_held", n, 30);
    i_encoder_done = 1'b1;
    @(posedge sys_clk); #1;
    i_encoder_done = 1'b0;
    @(posedge sys_clk); #1;
    chk("wait_prv", o_prv_encoder_state, 6'h13);
    chk("wait_error", o_error, 0);
`endif
    load(1'b0, 1'b1, 4, 8'hC0, 8'h01, 1'b1);
    chk("rr_en_run", o_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("rr_en", o_en, 0);
    chk("rr_ready", o_byte_ready, 0);
    chk("rr_busy", o_busy, 0);
    chk("rr_rate", o_code_rate, 0);
    chk("rr_enc", o_encoder_data_frame, 0);
    chk("rr_prv", o_prv_encoder_state, 0);
    chk("rr_error", o_error, 0);
    #3 rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("rr_ready_rel", o_byte_ready, 1);
    chk("rr_busy_rel", o_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/endec_frame_loader.md
ENDEC_FRAME_LOADER -- requirements
Module: endec_frame_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles while a frame is in flight (used only when the timeout feature is compiled in).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_mode  input  1  0 = encode frame, 1 = decode frame.
REQ-005 SHALL have port i_code_rate  input  1  0 = rate 1/2, 1 = rate 1/3.
REQ-006 SHALL have port i_byte_data  input  8  incoming payload byte.
REQ-007 SHALL have port i_byte_valid  input  1  byte present.
REQ-008 SHALL have port o_byte_ready  output  1  loader can accept a byte.
REQ-009 SHALL have port i_flush  input  1  zero-pad and launch the partial frame.
REQ-010 SHALL have port i_stream_clear  input  1  zero the carried encoder state.
REQ-011 SHALL have port o_en  output  1  level enable to the codec.
REQ-012 SHALL have port o_code_rate  output  1  rate latched for the current frame.
REQ-013 SHALL have port o_encoder_data_frame  output  128  assembled encoder frame.
REQ-014 SHALL have port o_decoder_data_frame  output  384  assembled decoder frame.
REQ-015 SHALL have port o_prv_encoder_state  output  `MAX_STATE_REG_NUM  encoder state carried between frames.
REQ-016 SHALL have ports i_encoder_done and i_decoder_done  input  1 each  codec completion flags.
REQ-017 SHALL have port o_busy  output  1  high in FILL, RUN and DONE.
REQ-018 SHALL have port o_error  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE, FILL, RUN and DONE, with o_byte_ready = 1 in IDLE/FILL and 0 in RUN/DONE.
REQ-020 SHALL accept a byte on a rising edge where i_byte_valid && o_byte_ready, writing byte n to bits [8n+7:8n] of the selected frame.
REQ-021 SHALL latch i_mode and i_code_rate on the first byte accepted in IDLE, move to FILL, and ignore later changes to those inputs until the frame returns to IDLE.
REQ-022 SHALL set the target byte count to 16 for encode, 32 for decode at rate 1/2, and 48 for decode at rate 1/3, using a 6-bit counter.
REQ-023 SHALL leave unfilled frame bits at zero; for decode at rate 1/2, bits [383:256] are always 0.
REQ-024 SHALL go to RUN when the counter reaches the target, with o_en = 1 on the cycle after the last byte is accepted.
REQ-025 SHALL, on i_flush in FILL with at least one byte held, launch RUN on the next cycle with the remainder zero-padded.
REQ-026 SHALL ignore i_flush in IDLE.
REQ-027 SHALL, when i_flush and an accepted byte occur in the same cycle, include that byte before padding.
REQ-028 SHALL hold o_en, both frames and o_code_rate stable throughout RUN.
REQ-029 SHALL exit RUN only on the done flag matching the latched mode (i_encoder_done for encode, i_decoder_done for decode) and ignore the other flag.
REQ-030 SHALL drop o_en the cycle after the done flag and enter DONE for exactly 1 cycle.
REQ-031 SHALL, in DONE, clear both frames and the counter, then return to IDLE.
REQ-032 SHALL, in DONE for an encode frame, load o_prv_encoder_state with the pre-clear o_encoder_data_frame[127 -: `MAX_STATE_REG_NUM]; decode frames leave it unchanged.
REQ-033 SHALL zero o_prv_encoder_state on i_stream_clear in any state, with priority over the DONE update.

Reset
REQ-034 SHALL, while rst = 0 and regardless of current state or operation, force state IDLE and zero the counter, o_en, o_code_rate, both frames, o_prv_encoder_state, o_error, o_busy and o_byte_ready; o_byte_ready rises in the first cycle after release.

Configuration
REQ-035 SHALL, with FRAME_LOADER_TIMEOUT_EN defined, count cycles in RUN and, if no matching done arrives within TIMEOUT_CYCLES, drop o_en, set o_error (cleared only by reset) and pass through DONE as a normal completion without updating o_prv_encoder_state.
REQ-036 SHALL, with FRAME_LOADER_TIMEOUT_EN undefined, wait indefinitely in RUN and tie o_error to 0.

Verification
REQ-037 SHALL cover: encode, 16 bytes 0x00..0x0F -> o_en rises the cycle after byte 15; o_encoder_data_frame = 0x0F0E..0100; i_encoder_done -> o_en low next cycle; o_prv_encoder_state = top bits of 0x0F.
REQ-038 SHALL cover: decode at rate 1/2, 32 bytes 0xFF -> frame bits [255:0] all 1 and [383:256] = 0; o_en held until i_decoder_done, and i_encoder_done is ignored.
REQ-039 SHALL cover: decode at rate 1/3, 5 bytes then i_flush asserted together with byte 6 -> 6 bytes loaded, remaining 42 bytes zero, o_en the next cycle.
REQ-040 SHALL cover: i_mode toggled mid-FILL -> no effect; rst pulsed during RUN -> all outputs 0 and o_byte_ready = 1 after release.
REQ-041 SHALL cover: with FRAME_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no done -> o_en drops after 8 RUN cycles, o_error = 1, o_prv_encoder_state unchanged.
REQ-042 SHALL cover: i_stream_clear in the same cycle as the encode DONE -> o_prv_encoder_state = 0.
